data_ram_pipelined: RTL and testbench

Parametrised data memory for the processor datapath: a valid/ready request port, byte-lane write enables, a configurable pipelined read latency, a zero-fill sweep after reset and out-of-range detection. It sits between the load/store stage and the memory array. It replaces the tri-stated, combinational-read data RAM with a registered and fully synchronous interface.

---
 rtl/data_ram_pkg.sv | 33 +++
 rtl/data_ram_pipelined_rsp_pipe.sv | 62 ++++++
 rtl/data_ram_pipelined.sv | 132 +++++++++++++
 tb/tb_data_ram_pipelined.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_ram_pkg : shared types, limits and byte-lane merge for data_ram |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package data_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    localparam int RD_LAT_MAX = 4;
    localparam int DATA_W_MAX = 128;

    // Operates on the widest supported word; callers size-cast in and out.
    function automatic logic [DATA_W_MAX-1:0] be_merge(
        input logic [DATA_W_MAX-1:0]   oldWord,
        input logic [DATA_W_MAX-1:0]   newWord,
        input logic [DATA_W_MAX/8-1:0] be
    );
        logic [DATA_W_MAX-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < DATA_W_MAX/8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = newWord[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_pipelined_rsp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsp_pipe : RD_LAT-deep {valid, err, data} shift register            |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module rsp_pipe
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              InValid,
    input  logic              InErr,
    input  logic [DATA_W-1:0] InData,
    output logic              RspValid,
    output logic              RspErr,
    output logic [DATA_W-1:0] RspData
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_badRdLat
        $error("rsp_pipe: RD_LAT must be within 1..%0d", RD_LAT_MAX);
    end

    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_err;
    logic [DATA_W-1:0] r_data [RD_LAT];

    // Idle stages carry zeros so RspData/RspErr read 0 between responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid[0] <= 1'b0;
            r_err[0]   <= 1'b0;
            r_data[0]  <= '0;
        end else begin
            r_valid[0] <= InValid;
            r_err[0]   <= InValid & InErr;
            r_data[0]  <= InValid ? InData : '0;
        end
    end

    for (genvar s = 1; s < RD_LAT; s++) begin : g_stage
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_valid[s] <= 1'b0;
                r_err[s]   <= 1'b0;
                r_data[s]  <= '0;
            end else begin
                r_valid[s] <= r_valid[s-1];
                r_err[s]   <= r_err[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign RspValid = r_valid[RD_LAT-1];
    assign RspErr   = r_err[RD_LAT-1];
    assign RspData  = r_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/data_ram_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_ram_pipelined : valid/ready data RAM, byte enables, pipelined  |
// | read, zero-fill sweep after reset, out-of-range detection           |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module data_ram_pipelined
    import data_ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 256,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [ADDR_W-1:0]   ReqAddr,
    input  logic [DATA_W-1:0]   ReqWData,
    input  logic [DATA_W/8-1:0] ReqBE,
    output logic                RspValid,
    output logic [DATA_W-1:0]   RspData,
    output logic                RspErr,
    output logic                ErrSticky
);

    localparam int                 c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_CLR_LAST  = c_IDX_W'(DEPTH - 1);

    if (DATA_W < 8 || (DATA_W % 8) != 0 || DATA_W > DATA_W_MAX) begin : g_badDataW
        $error("data_ram_pipelined: DATA_W must be a multiple of 8, at most %0d", DATA_W_MAX);
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_badDepth
        $error("data_ram_pipelined: DEPTH must be within 1..2**ADDR_W");
    end
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_badRdLat
        $error("data_ram_pipelined: RD_LAT must be within 1..%0d", RD_LAT_MAX);
    end

    ram_state_t         r_state;
    ram_state_t         w_stateNext;
    logic [c_IDX_W-1:0] r_clrAddr;
    logic               r_errSticky;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_accept;
    logic               w_inRange;
    logic               w_memWrite;
    logic               w_clrWrite;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_rdWord;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            CLEAR: begin
                if (CLEAR_ON_RESET == 0 || r_clrAddr == c_CLR_LAST) begin
                    w_stateNext = RUN;
                end
            end
            RUN: w_stateNext = RUN;
        endcase
    end

    always_comb begin
        ReqReady = (r_state == RUN);
    end

    // Counter returns to 0 on the last sweep write so it never exceeds DEPTH-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_clrAddr <= '0;
        end else if (r_state == CLEAR && CLEAR_ON_RESET != 0) begin
            r_clrAddr <= (r_clrAddr == c_CLR_LAST) ? '0 : r_clrAddr + 1'b1;
        end
    end

    assign w_accept   = ReqValid & ReqReady & ~RST;
    assign w_inRange  = ({1'b0, ReqAddr} < c_DEPTH_EXT);
    assign w_idx      = ReqAddr[c_IDX_W-1:0];
    assign w_memWrite = w_accept & ReqWrite & w_inRange;
    assign w_clrWrite = (r_state == CLEAR) && (CLEAR_ON_RESET != 0) && !RST;
    assign w_rdWord   = w_inRange ? r_mem[w_idx] : '0;

    always_ff @(posedge CLK) begin
        if (w_clrWrite) begin
            r_mem[r_clrAddr] <= '0;
        end else if (w_memWrite) begin
            r_mem[w_idx] <= DATA_W'(be_merge(DATA_W_MAX'(r_mem[w_idx]),
                                             DATA_W_MAX'(ReqWData),
                                             (DATA_W_MAX/8)'(ReqBE)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_errSticky <= 1'b0;
        end else if (w_accept && !w_inRange) begin
            r_errSticky <= 1'b1;
        end
    end

    assign ErrSticky = r_errSticky;

    rsp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rspPipe (
        .CLK      (CLK),
        .RST      (RST),
        .InValid  (w_accept & ~ReqWrite),
        .InErr    (~w_inRange),
        .InData   (w_rdWord),
        .RspValid (RspValid),
        .RspErr   (RspErr),
        .RspData  (RspData)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_ram_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_ram_pipelined : four DUTs (RD_LAT 1..4, DEPTH 256/200) on a |
// | shared request stream, checked every cycle against a table model    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_data_ram_pipelined;

    localparam int NI     = 4;
    localparam int MAXCYC = 2048;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReqValid;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [15:0] ReqWData;
    logic [1:0]  ReqBE;

    logic [NI-1:0] rdy, rv, re, es;
    logic [15:0]   rd [NI];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_ram_pipelined #(
            .DATA_W         (16),
            .ADDR_W         (16),
            .DEPTH          ((g == 0) ? 256 : 200),
            .RD_LAT         (g + 1),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .ReqValid  (ReqValid),
            .ReqReady  (rdy[g]),
            .ReqWrite  (ReqWrite),
            .ReqAddr   (ReqAddr),
            .ReqWData  (ReqWData),
            .ReqBE     (ReqBE),
            .RspValid  (rv[g]),
            .RspData   (rd[g]),
            .RspErr    (re[g]),
            .ErrSticky (es[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rstEdge = -100000;

    logic [15:0] mdl    [NI][256];
    logic        sticky [NI];
    // Expected response indexed by the cycle after whose edge it is visible.
    logic        expV   [NI][MAXCYC];
    logic        expE   [NI][MAXCYC];
    logic [15:0] expD   [NI][MAXCYC];

    function automatic int depthOf(int k);
        return (k == 0) ? 256 : 200;
    endfunction

    task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cycle %0d: got %h expected %h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic modelEdge();
        for (int k = 0; k < NI; k++) begin
            if (RST) begin
                rstEdge = cyc;
                sticky[k] = 1'b0;
                for (int a = 0; a < 256; a++) mdl[k][a] = 16'h0000;
                for (int c = cyc; c < cyc + 8 && c < MAXCYC; c++) begin
                    expV[k][c] = 1'b0; expE[k][c] = 1'b0; expD[k][c] = 16'h0000;
                end
            end else if (ReqValid && (cyc - 1 >= rstEdge + depthOf(k))) begin
                int a;
                bit ok;
                a  = int'(ReqAddr);
                ok = (a < depthOf(k));
                if (!ok) sticky[k] = 1'b1;
                if (ReqWrite) begin
                    if (ok) begin
                        for (int l = 0; l < 2; l++)
                            if (ReqBE[l]) mdl[k][a][8*l +: 8] = ReqWData[8*l +: 8];
                    end
                end else if (cyc + k < MAXCYC) begin
                    expV[k][cyc + k] = 1'b1;
                    expE[k][cyc + k] = !ok;
                    expD[k][cyc + k] = ok ? mdl[k][a] : 16'h0000;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        modelEdge();
        @(negedge CLK);
        for (int k = 0; k < NI; k++) begin
            chk("ReqReady",  k, 16'(rdy[k]), 16'(cyc >= rstEdge + depthOf(k)));
            chk("RspValid",  k, 16'(rv[k]),  16'(expV[k][cyc]));
            chk("RspErr",    k, 16'(re[k]),  16'(expE[k][cyc]));
            chk("RspData",   k, rd[k],       expD[k][cyc]);
            chk("ErrSticky", k, 16'(es[k]),  16'(sticky[k]));
        end
    endtask

    task automatic idle(int n);
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(int a, logic [15:0] d, logic [1:0] be);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'(a); ReqWData = d; ReqBE = be;
        tick();
        ReqValid = 1'b0;
    endtask

    task automatic rdReq(int a);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'(a);
        tick();
        ReqValid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            sticky[k] = 1'b0;
            for (int c = 0; c < MAXCYC; c++) begin
                expV[k][c] = 1'b0; expE[k][c] = 1'b0; expD[k][c] = 16'h0000;
            end
        end
        RST = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
        ReqAddr = '0; ReqWData = '0; ReqBE = '0;
        tick();
        RST = 1'b0;
        idle(258);

        rdReq(0); rdReq(128); rdReq(255);
        idle(5);

        wr(5, 16'hABCD, 2'b11); wr(5, 16'h1234, 2'b01); rdReq(5);
        wr(5, 16'hFFFF, 2'b00); rdReq(5);
        idle(5);

        wr(1, 16'h0011, 2'b11); wr(2, 16'h0022, 2'b11); wr(3, 16'h0033, 2'b11);
        rdReq(1); rdReq(2); rdReq(3);
        idle(5);

        wr(7, 16'hBEEF, 2'b11); rdReq(7);
        idle(5);

        wr(250, 16'h5555, 2'b11); rdReq(250); rdReq(199);
        idle(5);

        for (int i = 0; i < 200; i++) begin
            ReqValid = 1'($urandom_range(0, 3) != 0);
            ReqWrite = 1'($urandom);
            ReqAddr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(200, 300))
                                                   : 16'($urandom_range(0, 199));
            ReqWData = 16'($urandom);
            ReqBE    = 2'($urandom);
            tick();
        end
        idle(6);

        wr(9, 16'hC0DE, 2'b11);
        rdReq(9);
        RST = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'd9;
        tick();
        RST = 1'b0; ReqValid = 1'b0;
        idle(258);

        rdReq(7); rdReq(9);
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
